// File: rtl/ftdi_bridge.sv
// FTDI 245-style parallel FIFO bus bridge with one FWFT FIFO per direction and
// round-robin read/write arbitration. Define FTDI_BRIDGE_STATS_EN for byte counters.

module ftdi_bridge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ftdi_bridge #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int STROBE_CYCLES = 4,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                          clk_pll,
  input  logic                          reset,
  inout  wire  [DATA_WIDTH-1:0]         FTDI_data,
  input  logic                          FTDI_data_avilable,
  output logic                          FTDI_pop_data,
  input  logic                          FTDI_empty_for_write,
  output logic                          FTDI_push_data,
  output logic [DATA_WIDTH-1:0]         FIFO_output_data,
  output logic                          FIFO_empty,
  input  logic                          FIFO_pop_data,
  input  logic [DATA_WIDTH-1:0]         FIFO_input_data,
  input  logic                          FIFO_push_data,
  output logic                          FIFO_full,
  output logic [$clog2(DEPTH+1)-1:0]    rx_level,
  output logic [$clog2(DEPTH+1)-1:0]    tx_level,
  output logic                          tx_overflow,
`ifdef FTDI_BRIDGE_STATS_EN
  output logic [31:0]                   rx_byte_count,
  output logic [31:0]                   tx_byte_count,
`endif
  output logic [2:0]                    fsm_state
);
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RD_STROBE = 3'd1;
  localparam logic [2:0] ST_WR_SETUP  = 3'd2;
  localparam logic [2:0] ST_WR_STROBE = 3'd3;
  localparam logic [2:0] ST_WR_HOLD   = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;

  localparam int MAXC     = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int CW       = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [2:0] ST_AFTER = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic                  last_rx;
  logic [DATA_WIDTH-1:0] hold_q;

  logic                  rx_full;
  logic                  tx_empty;
  logic [DATA_WIDTH-1:0] tx_head;
  logic                  rx_ok;
  logic                  tx_ok;
  logic                  rd_start;
  logic                  wr_start;
  logic                  strobe_last;
  logic                  rx_push;
  logic                  tx_pop;
  logic                  bus_drive;

  assign rx_ok       = FTDI_data_avilable && !rx_full;
  assign tx_ok       = FTDI_empty_for_write && !tx_empty;
  // When both sides are eligible, serve the direction not served last time.
  assign rd_start    = rx_ok && (!tx_ok || !last_rx);
  assign wr_start    = tx_ok && !rd_start;
  assign strobe_last = (cnt == CW'(STROBE_CYCLES - 1));
  assign rx_push     = (state == ST_RD_STROBE) && strobe_last;
  assign tx_pop      = (state == ST_IDLE) && wr_start;

  assign FTDI_pop_data  = (state == ST_RD_STROBE);
  assign FTDI_push_data = (state == ST_WR_STROBE);
  assign bus_drive      = (state == ST_WR_SETUP) || (state == ST_WR_STROBE) ||
                          (state == ST_WR_HOLD);
  assign FTDI_data      = bus_drive ? hold_q : 'z;
  assign FIFO_full      = !tx_empty && (tx_level == $bits(tx_level)'(DEPTH));
  assign fsm_state      = state;

  ftdi_bridge_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk_pll),
    .reset (reset),
    .push  (rx_push),
    .wdata (FTDI_data),
    .pop   (FIFO_pop_data),
    .rdata (FIFO_output_data),
    .empty (FIFO_empty),
    .full  (rx_full),
    .level (rx_level)
  );

  logic tx_full_int;

  ftdi_bridge_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk_pll),
    .reset (reset),
    .push  (FIFO_push_data),
    .wdata (FIFO_input_data),
    .pop   (tx_pop),
    .rdata (tx_head),
    .empty (tx_empty),
    .full  (tx_full_int),
    .level (tx_level)
  );

  always_ff @(posedge clk_pll) begin
    if (reset) begin
      tx_overflow <= 1'b0;
    end else if (FIFO_push_data && tx_full_int) begin
      tx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_pll) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      last_rx <= 1'b1;
      hold_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (rd_start) begin
            state   <= ST_RD_STROBE;
            last_rx <= 1'b1;
          end else if (wr_start) begin
            state   <= ST_WR_SETUP;
            last_rx <= 1'b0;
            hold_q  <= tx_head;
          end
        end
        ST_RD_STROBE: begin
          if (strobe_last) begin
            cnt   <= '0;
            state <= ST_AFTER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WR_SETUP: begin
          cnt   <= '0;
          state <= ST_WR_STROBE;
        end
        ST_WR_STROBE: begin
          if (strobe_last) begin
            cnt   <= '0;
            state <= ST_WR_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WR_HOLD: begin
          cnt   <= '0;
          state <= ST_AFTER;
        end
        ST_GAP: begin
          if (cnt == CW'(GAP_LAST)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FTDI_BRIDGE_STATS_EN
  always_ff @(posedge clk_pll) begin
    if (reset) begin
      rx_byte_count <= '0;
      tx_byte_count <= '0;
    end else begin
      if (rx_push) rx_byte_count <= rx_byte_count + 32'd1;
      if ((state == ST_WR_STROBE) && strobe_last) tx_byte_count <= tx_byte_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ftdi_bridge.sv
// Directed bench for ftdi_bridge with default parameters; a small FTDI-side
// driver on the shared bus and an expected-byte queue for the TX path.

module tb_ftdi_bridge;
  localparam int W  = 8;
  localparam int LW = 5;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_STROBE = 3'd1;
  localparam logic [2:0] S_WR_SETUP  = 3'd2;
  localparam logic [2:0] S_WR_STROBE = 3'd3;
  localparam logic [2:0] S_WR_HOLD   = 3'd4;
  localparam logic [2:0] S_GAP       = 3'd5;

  logic          clk_pll = 1'b0;
  logic          reset;
  wire  [W-1:0]  FTDI_data;
  logic          FTDI_data_avilable;
  logic          FTDI_pop_data;
  logic          FTDI_empty_for_write;
  logic          FTDI_push_data;
  logic [W-1:0]  FIFO_output_data;
  logic          FIFO_empty;
  logic          FIFO_pop_data;
  logic [W-1:0]  FIFO_input_data;
  logic          FIFO_push_data;
  logic          FIFO_full;
  logic [LW-1:0] rx_level;
  logic [LW-1:0] tx_level;
  logic          tx_overflow;
  logic [2:0]    fsm_state;
`ifdef FTDI_BRIDGE_STATS_EN
  logic [31:0]   rx_byte_count;
  logic [31:0]   tx_byte_count;
`endif

  logic          tb_drive_en;
  logic [W-1:0]  tb_val;
  assign FTDI_data = tb_drive_en ? tb_val : 'z;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk_pll = ~clk_pll;

  ftdi_bridge dut (
    .clk_pll              (clk_pll),
    .reset                (reset),
    .FTDI_data            (FTDI_data),
    .FTDI_data_avilable   (FTDI_data_avilable),
    .FTDI_pop_data        (FTDI_pop_data),
    .FTDI_empty_for_write (FTDI_empty_for_write),
    .FTDI_push_data       (FTDI_push_data),
    .FIFO_output_data     (FIFO_output_data),
    .FIFO_empty           (FIFO_empty),
    .FIFO_pop_data        (FIFO_pop_data),
    .FIFO_input_data      (FIFO_input_data),
    .FIFO_push_data       (FIFO_push_data),
    .FIFO_full            (FIFO_full),
    .rx_level             (rx_level),
    .tx_level             (tx_level),
    .tx_overflow          (tx_overflow),
`ifdef FTDI_BRIDGE_STATS_EN
    .rx_byte_count        (rx_byte_count),
    .tx_byte_count        (tx_byte_count),
`endif
    .fsm_state            (fsm_state)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk_pll);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [W-1:0] d);
    FIFO_input_data = d;
    FIFO_push_data  = 1'b1;
    step(1);
    FIFO_push_data  = 1'b0;
  endtask

  // Called with the FSM idle and a write about to start on the next edge.
  task automatic write_xfer(input logic [W-1:0] b, input int lvl_after);
    step(1);
    chk("wr_setup_state", fsm_state, S_WR_SETUP);
    chk("wr_setup_strobe", FTDI_push_data, 0);
    chk("wr_setup_bus", FTDI_data, b);
    chk("wr_setup_level", tx_level, lvl_after);
    step(1);
    chk("wr_strobe_first", FTDI_push_data, 1);
    chk("wr_strobe_bus", FTDI_data, b);
    step(3);
    chk("wr_strobe_last", FTDI_push_data, 1);
    chk("wr_strobe_last_bus", FTDI_data, b);
    step(1);
    chk("wr_hold_state", fsm_state, S_WR_HOLD);
    chk("wr_hold_strobe", FTDI_push_data, 0);
    chk("wr_hold_bus", FTDI_data, b);
    step(1);
    tb_val = 8'hC0;
    tb_drive_en = 1'b1;
    #1;
    chk("gap_state", fsm_state, S_GAP);
    chk("gap_bus_released", FTDI_data, 8'hC0);
    tb_drive_en = 1'b0;
    step(2);
    chk("wr_back_idle", fsm_state, S_IDLE);
  endtask

  initial begin
    int   rises;
    int   writes;
    logic prev_pop;
    logic prev_push;
    logic [7:0] ev [4];

    reset = 1'b1;
    FTDI_data_avilable = 1'b0;
    FTDI_empty_for_write = 1'b0;
    FIFO_pop_data = 1'b0;
    FIFO_push_data = 1'b0;
    FIFO_input_data = '0;
    tb_drive_en = 1'b0;
    tb_val = '0;

    // reset state
    step(2);
    chk("rst_state", fsm_state, S_IDLE);
    chk("rst_pop", FTDI_pop_data, 0);
    chk("rst_push", FTDI_push_data, 0);
    chk("rst_empty", FIFO_empty, 1);
    chk("rst_full", FIFO_full, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_overflow", tx_overflow, 0);

    // single read of 0xA5; avail drops mid-strobe without aborting it
    reset = 1'b0;
    tb_val = 8'hA5;
    tb_drive_en = 1'b1;
    FTDI_data_avilable = 1'b1;
    step(1);
    chk("rd_pop_first", FTDI_pop_data, 1);
    FTDI_data_avilable = 1'b0;
    step(3);
    chk("rd_pop_fourth", FTDI_pop_data, 1);
    chk("rd_still_empty", FIFO_empty, 1);
    step(1);
    chk("rd_pop_done", FTDI_pop_data, 0);
    chk("rd_empty_falls", FIFO_empty, 0);
    chk("rd_data", FIFO_output_data, 8'hA5);
    chk("rd_level", rx_level, 1);
    step(2);
    chk("rd_back_idle", fsm_state, S_IDLE);
    FIFO_pop_data = 1'b1;
    step(1);
    FIFO_pop_data = 1'b0;
    chk("rd_popped_empty", FIFO_empty, 1);
    chk("rd_popped_level", rx_level, 0);
    tb_drive_en = 1'b0;

    // three writes in order
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    chk("wr_preload_level", tx_level, 3);
    FTDI_empty_for_write = 1'b1;
    write_xfer(8'h11, 2);
    write_xfer(8'h22, 1);
    write_xfer(8'h33, 0);
    step(2);
    chk("wr_done_idle", fsm_state, S_IDLE);
    chk("wr_done_level", tx_level, 0);
    FTDI_empty_for_write = 1'b0;

    // RX backpressure: 16 reads then stop; one pop allows exactly one more
    FTDI_data_avilable = 1'b1;
    tb_drive_en = 1'b1;
    rises = 0;
    prev_pop = 1'b0;
    for (int i = 0; i < 130; i++) begin
      if (FTDI_pop_data && !prev_pop) begin
        tb_val = 8'(8'h80 + rises);
        rises++;
      end
      prev_pop = FTDI_pop_data;
      step(1);
    end
    chk("fill_reads", rises, 16);
    chk("fill_level", rx_level, 16);
    chk("fill_pop_low", FTDI_pop_data, 0);
    chk("fill_head", FIFO_output_data, 8'h80);
    FIFO_pop_data = 1'b1;
    step(1);
    FIFO_pop_data = 1'b0;
    prev_pop = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (FTDI_pop_data && !prev_pop) begin
        tb_val = 8'(8'h80 + rises);
        rises++;
      end
      prev_pop = FTDI_pop_data;
      step(1);
    end
    chk("refill_reads", rises, 17);
    chk("refill_level", rx_level, 16);
    chk("refill_pop_low", FTDI_pop_data, 0);
    FTDI_data_avilable = 1'b0;
    tb_drive_en = 1'b0;
    FIFO_pop_data = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", FIFO_output_data, 32'(8'h81 + i));
      step(1);
    end
    FIFO_pop_data = 1'b0;
    chk("drain_empty", FIFO_empty, 1);

    // arbitration: both eligible, TX served first after reset
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    push_tx(8'h5C);
    push_tx(8'h6D);
    FTDI_data_avilable = 1'b1;
    FTDI_empty_for_write = 1'b1;
    tb_val = 8'h3E;
    rises = 0;
    prev_pop = 1'b0;
    prev_push = 1'b0;
    for (int i = 0; i < 4; i++) ev[i] = "-";
    for (int i = 0; i < 40; i++) begin
      if (FTDI_pop_data && !prev_pop && rises < 4) begin
        ev[rises] = "R";
        rises++;
      end
      if (FTDI_push_data && !prev_push && rises < 4) begin
        ev[rises] = "W";
        rises++;
      end
      prev_pop = FTDI_pop_data;
      prev_push = FTDI_push_data;
      tb_drive_en = FTDI_pop_data;
      step(1);
    end
    chk("arb_0", ev[0], "W");
    chk("arb_1", ev[1], "R");
    chk("arb_2", ev[2], "W");
    chk("arb_3", ev[3], "R");
    FTDI_data_avilable = 1'b0;
    FTDI_empty_for_write = 1'b0;
    tb_drive_en = 1'b0;

    // TX overflow: 17 pushes, only 16 kept and transmitted
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    FIFO_push_data = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      FIFO_input_data = 8'(i);
      if (i <= 16) exp_q.push_back(8'(i));
      step(1);
      if (i == 16) begin
        chk("ovf_full_at16", FIFO_full, 1);
        chk("ovf_clear_at16", tx_overflow, 0);
      end
    end
    FIFO_push_data = 1'b0;
    chk("ovf_level", tx_level, 16);
    chk("ovf_full", FIFO_full, 1);
    chk("ovf_flag", tx_overflow, 1);
    FTDI_empty_for_write = 1'b1;
    writes = 0;
    prev_push = 1'b0;
    for (int i = 0; i < 160; i++) begin
      if (FTDI_push_data && !prev_push) begin
        writes++;
        if (exp_q.size() == 0) chk("ovf_extra_write", 1, 0);
        else chk("ovf_write_byte", FTDI_data, exp_q.pop_front());
      end
      prev_push = FTDI_push_data;
      step(1);
    end
    chk("ovf_write_count", writes, 16);
    chk("ovf_queue_left", exp_q.size(), 0);
    chk("ovf_tx_level_end", tx_level, 0);
    chk("ovf_sticky", tx_overflow, 1);

    // reset during the 2nd WR_STROBE clock
    FTDI_empty_for_write = 1'b0;
    push_tx(8'h77);
    push_tx(8'h88);
    FTDI_empty_for_write = 1'b1;
    step(1);
    chk("mid_setup", fsm_state, S_WR_SETUP);
    step(2);
    chk("mid_strobe2", FTDI_push_data, 1);
    chk("mid_strobe2_state", fsm_state, S_WR_STROBE);
    reset = 1'b1;
    step(1);
    tb_val = 8'hC0;
    tb_drive_en = 1'b1;
    #1;
    chk("mid_rst_strobe", FTDI_push_data, 0);
    chk("mid_rst_bus", FTDI_data, 8'hC0);
    chk("mid_rst_level", tx_level, 0);
    chk("mid_rst_overflow", tx_overflow, 0);
    chk("mid_rst_state", fsm_state, S_IDLE);
    tb_drive_en = 1'b0;
    reset = 1'b0;
    FTDI_empty_for_write = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
